// File: rtl/clint_ctrl.sv
// Core-local trap/interrupt sequencer: accepts ECALL/EBREAK/MRET/timer IRQ in EX,
// stalls the pipeline while writing mepc/mcause/mstatus, then issues a one-cycle redirect.
module clint_ctrl #(
    parameter logic [31:0] IRQ_CAUSE   = 32'h8000_0007,
    parameter logic [31:0] ECALL_CAUSE = 32'd11,
    parameter logic [31:0] EBRK_CAUSE  = 32'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        irq_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_mstatus_i,
    output logic        hold_flag_o,
    output logic        csr_we_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        int_assert_o,
    output logic [31:0] int_addr_o
);

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEPC,
        S_MCAUSE,
        S_MSTATUS,
        S_DONE,
        S_MRET,
        S_MRET_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] cause_reg, cause_next;
    logic [31:0] epc_reg, epc_next;

    logic is_ecall, is_ebreak, is_mret, irq_take;

    assign is_ecall  = (inst_i == INST_ECALL);
    assign is_ebreak = (inst_i == INST_EBREAK);
    assign is_mret   = (inst_i == INST_MRET);
    assign irq_take  = irq_i && csr_mstatus_i[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cause_reg <= '0;
            epc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cause_reg <= cause_next;
            epc_reg   <= epc_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cause_next   = cause_reg;
        epc_next     = epc_reg;
        hold_flag_o  = 1'b0;
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;

        case (state_reg)
            S_IDLE: begin
                // Accept is gated by rst_n so outputs stay quiet while reset is held.
                if (rst_n) begin
                    if (is_ecall || is_ebreak) begin
                        hold_flag_o = 1'b1;
                        cause_next  = is_ecall ? ECALL_CAUSE : EBRK_CAUSE;
                        epc_next    = inst_addr_i;
                        state_next  = S_MEPC;
                    end else if (is_mret) begin
                        hold_flag_o = 1'b1;
                        state_next  = S_MRET;
                    end else if (irq_take) begin
                        // Resume at the branch target if EX is taking a branch.
                        hold_flag_o = 1'b1;
                        cause_next  = IRQ_CAUSE;
                        epc_next    = jump_flag_i ? jump_addr_i : inst_addr_i;
                        state_next  = S_MEPC;
                    end
                end
            end
            S_MEPC: begin
                hold_flag_o = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MEPC;
                csr_wdata_o = epc_reg;
                state_next  = S_MCAUSE;
            end
            S_MCAUSE: begin
                hold_flag_o = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MCAUSE;
                csr_wdata_o = cause_reg;
                state_next  = S_MSTATUS;
            end
            S_MSTATUS: begin
                hold_flag_o = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MSTATUS;
                csr_wdata_o = {csr_mstatus_i[31:8], csr_mstatus_i[3],
                               csr_mstatus_i[6:4], 1'b0, csr_mstatus_i[2:0]};
                state_next  = S_DONE;
            end
            S_DONE: begin
                hold_flag_o  = 1'b1;
                int_assert_o = 1'b1;
                int_addr_o   = csr_mtvec_i;
                state_next   = S_IDLE;
            end
            S_MRET: begin
                hold_flag_o = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MSTATUS;
                csr_wdata_o = {csr_mstatus_i[31:8], 1'b1,
                               csr_mstatus_i[6:4], csr_mstatus_i[7], csr_mstatus_i[2:0]};
                state_next  = S_MRET_DONE;
            end
            S_MRET_DONE: begin
                hold_flag_o  = 1'b1;
                int_assert_o = 1'b1;
                int_addr_o   = csr_mepc_i;
                state_next   = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_clint_ctrl.sv
// Directed, table-driven bench for clint_ctrl plus hand-written reset sequences.
module tb_clint_ctrl;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] MTVEC  = 32'h0000_0200;
    localparam logic [31:0] IRQC   = 32'h8000_0007;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_i, inst_addr_i, jump_addr_i;
    logic        jump_flag_i, irq_i;
    logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
    logic        hold_flag_o, csr_we_o, int_assert_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o, int_addr_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    clint_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inst_i        (inst_i),
        .inst_addr_i   (inst_addr_i),
        .jump_flag_i   (jump_flag_i),
        .jump_addr_i   (jump_addr_i),
        .irq_i         (irq_i),
        .csr_mtvec_i   (csr_mtvec_i),
        .csr_mepc_i    (csr_mepc_i),
        .csr_mstatus_i (csr_mstatus_i),
        .hold_flag_o   (hold_flag_o),
        .csr_we_o      (csr_we_o),
        .csr_waddr_o   (csr_waddr_o),
        .csr_wdata_o   (csr_wdata_o),
        .int_assert_o  (int_assert_o),
        .int_addr_o    (int_addr_o)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        jf;
        logic [31:0] ja;
        logic        irq;
        logic [31:0] mst;
        logic [31:0] mepc;
        logic        hold;
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic        ai;
        logic [31:0] iaddr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic [31:0] inst, logic [31:0] addr, logic jf, logic [31:0] ja,
                               logic irq, logic [31:0] mst, logic [31:0] mepc,
                               logic hold, logic we, logic [11:0] waddr, logic [31:0] wdata,
                               logic ai, logic [31:0] iaddr);
        vec_t r;
        r.inst = inst; r.addr = addr; r.jf = jf; r.ja = ja; r.irq = irq; r.mst = mst;
        r.mepc = mepc; r.hold = hold; r.we = we; r.waddr = waddr; r.wdata = wdata;
        r.ai = ai; r.iaddr = iaddr;
        return r;
    endfunction

    task automatic check(string name, logic hold, logic we, logic [11:0] waddr,
                         logic [31:0] wdata, logic ai, logic [31:0] iaddr);
        logic [78:0] act, exp;
        act = {hold_flag_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o};
        exp = {hold, we, waddr, wdata, ai, iaddr};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got hold=%b we=%b waddr=%h wdata=%h ia=%b iaddr=%h, want hold=%b we=%b waddr=%h wdata=%h ia=%b iaddr=%h",
                     name, hold_flag_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o,
                     hold, we, waddr, wdata, ai, iaddr);
        end else begin
            $display("ok   %s: hold=%b we=%b waddr=%h wdata=%h ia=%b iaddr=%h",
                     name, hold_flag_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o);
        end
    endtask

    task automatic drive(logic [31:0] inst, logic [31:0] addr, logic jf, logic [31:0] ja,
                         logic irq, logic [31:0] mst, logic [31:0] mepc);
        inst_i = inst; inst_addr_i = addr; jump_flag_i = jf; jump_addr_i = ja;
        irq_i = irq; csr_mstatus_i = mst; csr_mepc_i = mepc;
    endtask

    initial begin
        rst_n = 1'b0;
        csr_mtvec_i = MTVEC;
        drive(NOP, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

        // ECALL at 0x100, mstatus=0x8
        vecs.push_back(v(ECALL, 32'h100, 0, 0, 0, 32'h08, 0, 1, 0, 12'h000, 32'h0,   0, 32'h0));
        vecs.push_back(v(NOP,   32'h104, 0, 0, 0, 32'h08, 0, 1, 1, 12'h341, 32'h100, 0, 32'h0));
        vecs.push_back(v(NOP,   32'h104, 0, 0, 0, 32'h08, 0, 1, 1, 12'h342, 32'd11,  0, 32'h0));
        vecs.push_back(v(NOP,   32'h104, 0, 0, 0, 32'h08, 0, 1, 1, 12'h300, 32'h80,  0, 32'h0));
        vecs.push_back(v(NOP,   32'h104, 0, 0, 0, 32'h80, 0, 1, 0, 12'h000, 32'h0,   1, MTVEC));
        vecs.push_back(v(NOP,   32'h104, 0, 0, 0, 32'h80, 0, 0, 0, 12'h000, 32'h0,   0, 32'h0));
        // IRQ with MIE=1 while EX takes a branch to 0x340
        vecs.push_back(v(NOP, 32'h120, 1, 32'h340, 1, 32'h08, 0, 1, 0, 12'h000, 32'h0,   0, 32'h0));
        vecs.push_back(v(NOP, 32'h120, 1, 32'h340, 1, 32'h08, 0, 1, 1, 12'h341, 32'h340, 0, 32'h0));
        vecs.push_back(v(NOP, 32'h120, 0, 32'h0,   1, 32'h08, 0, 1, 1, 12'h342, IRQC,    0, 32'h0));
        vecs.push_back(v(NOP, 32'h120, 0, 32'h0,   1, 32'h08, 0, 1, 1, 12'h300, 32'h80,  0, 32'h0));
        vecs.push_back(v(NOP, 32'h120, 0, 32'h0,   1, 32'h80, 0, 1, 0, 12'h000, 32'h0,   1, MTVEC));
        // IRQ held with MIE=0 is ignored; raising MIE accepts it in the same cycle
        vecs.push_back(v(NOP, 32'h130, 0, 0, 1, 32'h80, 0, 0, 0, 12'h000, 32'h0,   0, 32'h0));
        vecs.push_back(v(NOP, 32'h130, 0, 0, 1, 32'h80, 0, 0, 0, 12'h000, 32'h0,   0, 32'h0));
        vecs.push_back(v(NOP, 32'h130, 0, 0, 1, 32'h88, 0, 1, 0, 12'h000, 32'h0,   0, 32'h0));
        vecs.push_back(v(NOP, 32'h130, 0, 0, 1, 32'h88, 0, 1, 1, 12'h341, 32'h130, 0, 32'h0));
        vecs.push_back(v(NOP, 32'h130, 0, 0, 1, 32'h88, 0, 1, 1, 12'h342, IRQC,    0, 32'h0));
        vecs.push_back(v(NOP, 32'h130, 0, 0, 1, 32'h88, 0, 1, 1, 12'h300, 32'h80,  0, 32'h0));
        vecs.push_back(v(NOP, 32'h130, 0, 0, 0, 32'h80, 0, 1, 0, 12'h000, 32'h0,   1, MTVEC));
        vecs.push_back(v(NOP, 32'h130, 0, 0, 0, 32'h80, 0, 0, 0, 12'h000, 32'h0,   0, 32'h0));
        // MRET, mstatus=0x80, mepc=0x104
        vecs.push_back(v(MRET, 32'h140, 0, 0, 0, 32'h80, 32'h104, 1, 0, 12'h000, 32'h0,  0, 32'h0));
        vecs.push_back(v(NOP,  32'h144, 0, 0, 0, 32'h80, 32'h104, 1, 1, 12'h300, 32'h88, 0, 32'h0));
        vecs.push_back(v(NOP,  32'h144, 0, 0, 0, 32'h88, 32'h104, 1, 0, 12'h000, 32'h0,  1, 32'h104));
        vecs.push_back(v(NOP,  32'h104, 0, 0, 0, 32'h88, 32'h104, 0, 0, 12'h000, 32'h0,  0, 32'h0));
        // ECALL and IRQ together: ECALL wins, IRQ then masked by cleared MIE
        vecs.push_back(v(ECALL, 32'h150, 0, 0, 1, 32'h08, 0, 1, 0, 12'h000, 32'h0,   0, 32'h0));
        vecs.push_back(v(NOP,   32'h154, 0, 0, 1, 32'h08, 0, 1, 1, 12'h341, 32'h150, 0, 32'h0));
        vecs.push_back(v(NOP,   32'h154, 0, 0, 1, 32'h08, 0, 1, 1, 12'h342, 32'd11,  0, 32'h0));
        vecs.push_back(v(NOP,   32'h154, 0, 0, 1, 32'h08, 0, 1, 1, 12'h300, 32'h80,  0, 32'h0));
        vecs.push_back(v(NOP,   32'h154, 0, 0, 1, 32'h80, 0, 1, 0, 12'h000, 32'h0,   1, MTVEC));
        vecs.push_back(v(NOP,   32'h154, 0, 0, 1, 32'h80, 0, 0, 0, 12'h000, 32'h0,   0, 32'h0));
        // EBREAK with other mstatus bits set: only bits 7 and 3 change
        vecs.push_back(v(EBREAK, 32'h160, 0, 0, 0, 32'h1808, 0, 1, 0, 12'h000, 32'h0,    0, 32'h0));
        vecs.push_back(v(NOP,    32'h164, 0, 0, 0, 32'h1808, 0, 1, 1, 12'h341, 32'h160,  0, 32'h0));
        vecs.push_back(v(NOP,    32'h164, 0, 0, 0, 32'h1808, 0, 1, 1, 12'h342, 32'd3,    0, 32'h0));
        vecs.push_back(v(NOP,    32'h164, 0, 0, 0, 32'h1808, 0, 1, 1, 12'h300, 32'h1880, 0, 32'h0));
        // Back-to-back: MRET accepted in the IDLE cycle right after DONE
        vecs.push_back(v(MRET,   32'h200, 0, 0, 0, 32'h1880, 32'h164, 1, 0, 12'h000, 32'h0,    1, MTVEC));
        vecs.push_back(v(MRET,   32'h200, 0, 0, 0, 32'h1880, 32'h164, 1, 0, 12'h000, 32'h0,    0, 32'h0));
        vecs.push_back(v(NOP,    32'h204, 0, 0, 0, 32'h1880, 32'h164, 1, 1, 12'h300, 32'h1888, 0, 32'h0));
        vecs.push_back(v(NOP,    32'h204, 0, 0, 0, 32'h1888, 32'h164, 1, 0, 12'h000, 32'h0,    1, 32'h164));
        vecs.push_back(v(NOP,    32'h164, 0, 0, 0, 32'h1888, 32'h164, 0, 0, 12'h000, 32'h0,    0, 32'h0));

        repeat (2) @(negedge clk);
        #1 check("reset_state", 0, 0, 12'h0, 32'h0, 0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].inst, vecs[i].addr, vecs[i].jf, vecs[i].ja,
                  vecs[i].irq, vecs[i].mst, vecs[i].mepc);
            #1 check($sformatf("vec%0d", i), vecs[i].hold, vecs[i].we, vecs[i].waddr,
                     vecs[i].wdata, vecs[i].ai, vecs[i].iaddr);
        end

        // Reset asserted while in S_MCAUSE aborts the trap immediately
        @(negedge clk);
        drive(ECALL, 32'h100, 0, 0, 0, 32'h08, 0);
        #1 check("rst_seq_accept", 1, 0, 12'h0, 32'h0, 0, 32'h0);
        @(negedge clk);
        drive(NOP, 32'h104, 0, 0, 0, 32'h08, 0);
        #1 check("rst_seq_mepc", 1, 1, 12'h341, 32'h100, 0, 32'h0);
        @(negedge clk);
        #1 check("rst_seq_mcause", 1, 1, 12'h342, 32'd11, 0, 32'h0);
        #1 rst_n = 1'b0;
        #1 check("rst_mid_mcause", 0, 0, 12'h0, 32'h0, 0, 32'h0);
        drive(ECALL, 32'h100, 0, 0, 1, 32'h08, 0);
        #1 check("rst_held_events", 0, 0, 12'h0, 32'h0, 0, 32'h0);
        @(negedge clk);
        drive(NOP, 32'h104, 0, 0, 0, 32'h08, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 check($sformatf("post_rst%0d", i), 0, 0, 12'h0, 32'h0, 0, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
